// File: rtl/ips2l_uart_rd_pkg.sv
// Shared constants for the UART-side read scheduler: FSM encoding, slave count,
// timeout counter width and the default data returned when a slave never answers.
package ips2l_uart_rd_pkg;

  localparam int NUM_SLV   = 4;
  localparam int TMO_CNT_W = 16;

  localparam logic [31:0] TMO_DATA_DEF = 32'hDEAD_BEEF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef logic [1:0] slv_sel_t;

  function automatic logic [NUM_SLV-1:0] sel_onehot(input slv_sel_t sel);
    logic [NUM_SLV-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/ips2l_uart_rd_tmo.sv
// Slave-ack timeout counter: cleared on issue, counts while enabled, saturates,
// and flags the terminal count only while it is being enabled.
module ips2l_uart_rd_tmo
  import ips2l_uart_rd_pkg::*;
#(
  parameter logic [TMO_CNT_W-1:0] TERM = 16'd1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMO_CNT_W-1:0] cnt_q;
  logic [TMO_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {TMO_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == TERM);

endmodule

// File: rtl/ips2l_uart_rd_sched.sv
// Arbitrates one UART read at a time onto four register slaves, returning slave
// data (or the fixed timeout/disabled status value) with a single read_ack pulse.
module ips2l_uart_rd_sched
  import ips2l_uart_rd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024,
  parameter logic [3:0]  SLV_EN      = 4'b1111,
  parameter logic [31:0] TMO_DATA    = TMO_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_req,
  input  logic [7:0]  uart_rd_addr,
  output logic        read_ack,
  output logic [31:0] status_bus,
  output logic [3:0]  slv_req,
  output logic [5:0]  slv_addr,
  input  logic [3:0]  slv_ack,
  input  logic [31:0] slv_data_0,
  input  logic [31:0] slv_data_1,
  input  logic [31:0] slv_data_2,
  input  logic [31:0] slv_data_3,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  logic [2:0]  state_q,  state_d;
  logic        req_q,    req_d;
  slv_sel_t    sel_q,    sel_d;
  logic [5:0]  addr_q,   addr_d;
  logic [31:0] status_q, status_d;
  logic        terr_q,   terr_d;

  logic        cnt_clr;
  logic        cnt_en;
  logic        tmo_tc;
  logic        tmo_set;
  logic        ack_sel;
  logic [31:0] sel_data;

  ips2l_uart_rd_tmo #(
    .TERM(TIMEOUT_CYC - 16'd1)
  ) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (tmo_tc)
  );

  always_comb begin
    sel_data = slv_data_0;
    case (sel_q)
      2'd0:    sel_data = slv_data_0;
      2'd1:    sel_data = slv_data_1;
      2'd2:    sel_data = slv_data_2;
      default: sel_data = slv_data_3;
    endcase
  end

  // Acks from non-selected slaves are masked off here, so only the addressed slave can complete a read.
  assign ack_sel = |(slv_ack & sel_onehot(sel_q));

  // read_req is registered once; the IDLE decision works on the sampled level.
  always_comb begin
    state_d  = state_q;
    req_d    = read_req;
    sel_d    = sel_q;
    addr_d   = addr_q;
    status_d = status_q;
    tmo_set  = 1'b0;
    cnt_clr  = (state_q == ST_ISSUE);
    cnt_en   = (state_q == ST_WAIT);

    case (state_q)
      ST_IDLE: begin
        if (req_q) begin
          sel_d  = uart_rd_addr[7:6];
          addr_d = uart_rd_addr[5:0];
          if (SLV_EN[uart_rd_addr[7:6]]) begin
            state_d = ST_ISSUE;
          end else begin
            status_d = 32'h0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack on the terminal-count cycle still wins over the timeout.
        if (ack_sel) begin
          status_d = sel_data;
          state_d  = ST_DONE;
        end else if (tmo_tc) begin
          status_d = TMO_DATA;
          tmo_set  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!req_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    terr_d = tmo_set | (terr_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      status_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      status_q <= status_d;
      terr_q   <= terr_d;
    end
  end

  assign read_ack    = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign slv_req     = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? sel_onehot(sel_q) : 4'h0;
  assign slv_addr    = addr_q;
  assign status_bus  = status_q;
  assign timeout_err = terr_q;

endmodule
